// File: rtl/fp_mul_pkg.sv
// ----------------------------------------------------------------------------
// fp_mul_pkg
// Shared types and helpers for the floating-point multiply path.
//   state_e   : sequencer FSM states (IDLE, CALC, DONE)
//   PORT0/1   : requester port identifiers
//   cnt_width : iteration counter width for a given stored-mantissa width
// ----------------------------------------------------------------------------
package fp_mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    // Counter must reach BIT_WIDTH+1 (one past the last step) without wrapping.
    function automatic int unsigned cnt_width(input int unsigned bit_width);
        return $clog2(bit_width + 2);
    endfunction

endpackage : fp_mul_pkg

// File: rtl/mantissa_shift_add_dp.sv
// ----------------------------------------------------------------------------
// mantissa_shift_add_dp
// Shift-and-add datapath for a (BIT_WIDTH+1)x(BIT_WIDTH+1) mantissa product.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   load            : capture {1,a_in}/{1,b_in} and clear the accumulator
//   step            : accumulate A << cnt when B[cnt] is set
//   cnt             : current step index
//   a_in, b_in      : stored operand mantissas (hidden bit implied)
//   mant, norm      : normalized/truncated result of the accumulator after the
//                     current step (combinational; valid on the final step)
// ----------------------------------------------------------------------------
module mantissa_shift_add_dp
    import fp_mul_pkg::*;
#(
    parameter  int unsigned BIT_WIDTH = 23,
    localparam int unsigned CNT_W     = cnt_width(BIT_WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 step,
    input  logic [CNT_W-1:0]     cnt,
    input  logic [BIT_WIDTH-1:0] a_in,
    input  logic [BIT_WIDTH-1:0] b_in,
    output logic [BIT_WIDTH-1:0] mant,
    output logic                 norm
);

    localparam int unsigned MW = BIT_WIDTH + 1;
    localparam int unsigned PW = 2 * BIT_WIDTH + 2;

    logic [MW-1:0] a_q, a_d;
    logic [MW-1:0] b_q, b_d;
    logic [PW-1:0] p_q, p_d;
    logic [PW-1:0] addend_c;
    logic [PW-1:0] sum_c;

    // Partial-product accumulate, operand load and normalize/truncate.
    always_comb begin
        a_d      = a_q;
        b_d      = b_q;
        p_d      = p_q;
        addend_c = b_q[cnt] ? (PW'(a_q) << cnt) : '0;
        sum_c    = p_q + addend_c;

        if (load) begin
            a_d = {1'b1, a_in};
            b_d = {1'b1, b_in};
            p_d = '0;
        end else if (step) begin
            p_d = sum_c;
        end

        // Product in [1,4): top bit set means the value is >= 2.0.
        norm = sum_c[PW-1];
        mant = norm ? sum_c[PW-2 -: BIT_WIDTH] : sum_c[PW-3 -: BIT_WIDTH];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q <= '0;
            b_q <= '0;
            p_q <= '0;
        end else begin
            a_q <= a_d;
            b_q <= b_d;
            p_q <= p_d;
        end
    end

endmodule : mantissa_shift_add_dp

// File: rtl/mantissa_mul_sequencer.sv
// ----------------------------------------------------------------------------
// mantissa_mul_sequencer
// Two-port, round-robin arbitrated iterative mantissa multiplier. One
// shift-and-add step per clock, result normalized and truncated toward zero.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   in_valid0/1           : operand request per port
//   in_ready0/1           : operand accept strobe per port (combinational)
//   in0_a/b, in1_a/b      : operand stored mantissas per port
//   out_valid/out_ready   : result handshake
//   out_id                : port that issued the result
//   out_mant              : normalized, truncated product mantissa
//   out_norm              : product >= 2.0, exponent needs +1
// ----------------------------------------------------------------------------
module mantissa_mul_sequencer
    import fp_mul_pkg::*;
#(
    parameter  int unsigned BIT_WIDTH = 23,
    localparam int unsigned CNT_W     = cnt_width(BIT_WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid0,
    input  logic                 in_valid1,
    output logic                 in_ready0,
    output logic                 in_ready1,
    input  logic [BIT_WIDTH-1:0] in0_a,
    input  logic [BIT_WIDTH-1:0] in0_b,
    input  logic [BIT_WIDTH-1:0] in1_a,
    input  logic [BIT_WIDTH-1:0] in1_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_id,
    output logic [BIT_WIDTH-1:0] out_mant,
    output logic                 out_norm
);

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 last_grant_q, last_grant_d;
    logic                 id_q, id_d;
    logic                 out_valid_q, out_valid_d;
    logic                 out_id_q, out_id_d;
    logic [BIT_WIDTH-1:0] out_mant_q, out_mant_d;
    logic                 out_norm_q, out_norm_d;

    logic                 grant0_c, grant1_c;
    logic                 acc0_c, acc1_c;
    logic                 sel_c;
    logic                 load_c, step_c;
    logic [BIT_WIDTH-1:0] op_a_c, op_b_c;
    logic [BIT_WIDTH-1:0] dp_mant;
    logic                 dp_norm;

    // Arbiter, next-state and output-register logic.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        id_d         = id_q;
        out_valid_d  = out_valid_q;
        out_id_d     = out_id_q;
        out_mant_d   = out_mant_q;
        out_norm_d   = out_norm_q;
        acc0_c       = 1'b0;
        acc1_c       = 1'b0;
        sel_c        = PORT0;
        load_c       = 1'b0;
        step_c       = 1'b0;

        // On a tie the port that did not win last time gets the grant.
        grant0_c = in_valid0 & (~in_valid1 | (last_grant_q == PORT1));
        grant1_c = in_valid1 & (~in_valid0 | (last_grant_q == PORT0));

        case (state_q)
            IDLE: begin
                // Reset suppresses the strobe so no requester sees a phantom accept.
                acc0_c = ~rst & grant0_c;
                acc1_c = ~rst & grant1_c;
                if (acc0_c | acc1_c) begin
                    sel_c        = acc1_c ? PORT1 : PORT0;
                    load_c       = 1'b1;
                    id_d         = sel_c;
                    last_grant_d = sel_c;
                    cnt_d        = '0;
                    state_d      = CALC;
                end
            end
            CALC: begin
                step_c = 1'b1;
                cnt_d  = cnt_q + CNT_W'(1);
                // Final step: the datapath's post-step value is the exact product.
                if (cnt_q == CNT_W'(BIT_WIDTH)) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                    out_id_d    = id_q;
                    out_mant_d  = dp_mant;
                    out_norm_d  = dp_norm;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        op_a_c = (sel_c == PORT1) ? in1_a : in0_a;
        op_b_c = (sel_c == PORT1) ? in1_b : in0_b;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            last_grant_q <= PORT1;
            id_q         <= PORT0;
            out_valid_q  <= 1'b0;
            out_id_q     <= PORT0;
            out_mant_q   <= '0;
            out_norm_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            id_q         <= id_d;
            out_valid_q  <= out_valid_d;
            out_id_q     <= out_id_d;
            out_mant_q   <= out_mant_d;
            out_norm_q   <= out_norm_d;
        end
    end

    mantissa_shift_add_dp #(
        .BIT_WIDTH (BIT_WIDTH)
    ) u_dp (
        .clk  (clk),
        .rst  (rst),
        .load (load_c),
        .step (step_c),
        .cnt  (cnt_q),
        .a_in (op_a_c),
        .b_in (op_b_c),
        .mant (dp_mant),
        .norm (dp_norm)
    );

    assign in_ready0 = acc0_c;
    assign in_ready1 = acc1_c;
    assign out_valid = out_valid_q;
    assign out_id    = out_id_q;
    assign out_mant  = out_mant_q;
    assign out_norm  = out_norm_q;

endmodule : mantissa_mul_sequencer

// File: tb/tb_mantissa_mul_sequencer.sv
// ----------------------------------------------------------------------------
// tb_mantissa_mul_sequencer
// Directed self-checking bench for mantissa_mul_sequencer with BIT_WIDTH = 23.
// Inputs change just after the falling edge; outputs are sampled on it.
// ----------------------------------------------------------------------------
module tb_mantissa_mul_sequencer;

    localparam int unsigned BW  = 23;
    localparam int          LAT = 25;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid0, in_valid1;
    logic          in_ready0, in_ready1;
    logic [BW-1:0] in0_a, in0_b, in1_a, in1_b;
    logic          out_valid, out_ready, out_id;
    logic [BW-1:0] out_mant;
    logic          out_norm;

    int errors = 0;
    int checks = 0;

    mantissa_mul_sequencer #(.BIT_WIDTH(BW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid0 (in_valid0),
        .in_valid1 (in_valid1),
        .in_ready0 (in_ready0),
        .in_ready1 (in_ready1),
        .in0_a     (in0_a),
        .in0_b     (in0_b),
        .in1_a     (in1_a),
        .in1_b     (in1_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_id    (out_id),
        .out_mant  (out_mant),
        .out_norm  (out_norm)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Present a request on one port until accepted; returns at accept edge + 1.
    task automatic send(input int port, input logic [BW-1:0] a, input logic [BW-1:0] b,
                        output bit ok);
        ok = 1'b0;
        if (port == 0) begin in_valid0 = 1'b1; in0_a = a; in0_b = b; end
        else           begin in_valid1 = 1'b1; in1_a = a; in1_b = b; end
        for (int i = 0; i < 80; i++) begin
            #1;
            if ((port == 0 && in_ready0 === 1'b1) || (port == 1 && in_ready1 === 1'b1)) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (ok) @(posedge clk);
        #1;
        if (port == 0) in_valid0 = 1'b0;
        else           in_valid1 = 1'b0;
    endtask

    // Cycles from the accept cycle to the first cycle with out_valid high.
    task automatic wait_valid(output int lat);
        lat = -1;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid0 = 1'b0; in_valid1 = 1'b0; out_ready = 1'b1;
        in0_a = '0; in0_b = '0; in1_a = '0; in1_b = '0;
        repeat (3) @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (out_mant !== 23'h0) begin errors++; $display("FAIL reset_out_mant: got %h expected 000000", out_mant); end
        checks++; if (out_norm !== 1'b0) begin errors++; $display("FAIL reset_out_norm: got %b expected 0", out_norm); end
        checks++; if (out_id !== 1'b0) begin errors++; $display("FAIL reset_out_id: got %b expected 0", out_id); end
        checks++; if (in_ready0 !== 1'b0 || in_ready1 !== 1'b0) begin
            errors++; $display("FAIL reset_in_ready: got %b%b expected 00", in_ready0, in_ready1);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_product(input string name, input int port, input logic [BW-1:0] a,
                                input logic [BW-1:0] b, input logic [BW-1:0] exp_m,
                                input logic exp_n);
        bit ok;
        int lat;
        send(port, a, b, ok);
        checks++; if (!ok) begin errors++; $display("FAIL %s_accept: got no in_ready expected accept", name); end
        wait_valid(lat);
        checks++; if (lat != LAT) begin errors++; $display("FAIL %s_latency: got %0d expected %0d", name, lat, LAT); end
        checks++; if (out_mant !== exp_m) begin errors++; $display("FAIL %s_mant: got %h expected %h", name, out_mant, exp_m); end
        checks++; if (out_norm !== exp_n) begin errors++; $display("FAIL %s_norm: got %b expected %b", name, out_norm, exp_n); end
        checks++; if (out_id !== 1'(port)) begin errors++; $display("FAIL %s_id: got %b expected %0d", name, out_id, port); end
    endtask

    task automatic test_arbitration();
        int  k;
        int  last_t;
        bit  both_hi;
        logic          exp_id;
        logic [BW-1:0] exp_m;
        logic          exp_n;
        rst = 1'b1;
        in_valid0 = 1'b1; in0_a = 23'h400000; in0_b = 23'h000000;
        in_valid1 = 1'b1; in1_a = 23'h200000; in1_b = 23'h600000;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (in_ready0 !== 1'b1 || in_ready1 !== 1'b0) begin
            errors++; $display("FAIL arb_first_grant: got %b%b expected 10", in_ready0, in_ready1);
        end
        k = 0; last_t = 0; both_hi = 1'b0;
        for (int t = 1; t <= 300 && k < 4; t++) begin
            @(negedge clk);
            if (in_ready0 === 1'b1 && in_ready1 === 1'b1) both_hi = 1'b1;
            if (out_valid === 1'b1) begin
                exp_id = k[0];
                exp_m  = exp_id ? 23'h0C0000 : 23'h400000;
                exp_n  = exp_id;
                checks++; if (out_id !== exp_id) begin errors++; $display("FAIL arb_id%0d: got %b expected %b", k, out_id, exp_id); end
                checks++; if (out_mant !== exp_m) begin errors++; $display("FAIL arb_mant%0d: got %h expected %h", k, out_mant, exp_m); end
                checks++; if (out_norm !== exp_n) begin errors++; $display("FAIL arb_norm%0d: got %b expected %b", k, out_norm, exp_n); end
                if (k > 0) begin
                    checks++; if (t - last_t != 26) begin errors++; $display("FAIL arb_gap%0d: got %0d expected 26", k, t - last_t); end
                end
                last_t = t;
                k++;
                if (k == 4) begin in_valid0 = 1'b0; in_valid1 = 1'b0; end
            end
        end
        in_valid0 = 1'b0; in_valid1 = 1'b0;
        checks++; if (k != 4) begin errors++; $display("FAIL arb_count: got %0d results expected 4", k); end
        checks++; if (both_hi) begin errors++; $display("FAIL arb_exclusive: got both in_ready high expected at most one"); end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        bit ok;
        int lat;
        out_ready = 1'b0;
        send(0, 23'h400000, 23'h400000, ok);
        checks++; if (!ok) begin errors++; $display("FAIL bp_accept: got no in_ready expected accept"); end
        wait_valid(lat);
        checks++; if (lat != LAT) begin errors++; $display("FAIL bp_latency: got %0d expected %0d", lat, LAT); end
        #1;
        in_valid1 = 1'b1; in1_a = 23'h200000; in1_b = 23'h600000;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_mant !== 23'h100000 || out_norm !== 1'b1 ||
                out_id !== 1'b0 || in_ready0 !== 1'b0 || in_ready1 !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold%0d: got v=%b m=%h n=%b id=%b rdy=%b%b expected v=1 m=100000 n=1 id=0 rdy=00",
                         i, out_valid, out_mant, out_norm, out_id, in_ready0, in_ready1);
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0 || in_ready1 !== 1'b1) begin
            errors++; $display("FAIL bp_release: got v=%b rdy1=%b expected v=0 rdy1=1", out_valid, in_ready1);
        end
        @(posedge clk);
        #1;
        in_valid1 = 1'b0;
        wait_valid(lat);
        checks++; if (lat != LAT) begin errors++; $display("FAIL bp_next_latency: got %0d expected %0d", lat, LAT); end
        checks++; if (out_id !== 1'b1 || out_mant !== 23'h0C0000 || out_norm !== 1'b1) begin
            errors++; $display("FAIL bp_next_result: got id=%b m=%h n=%b expected id=1 m=0c0000 n=1", out_id, out_mant, out_norm);
        end
    endtask

    task automatic test_reset_mid_calc();
        bit ok;
        bit seen;
        send(0, 23'h7FFFFF, 23'h7FFFFF, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rstmid_accept: got no in_ready expected accept"); end
        repeat (11) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (out_valid !== 1'b0 || out_mant !== 23'h0 || out_norm !== 1'b0) begin
            errors++; $display("FAIL rstmid_state: got v=%b m=%h n=%b expected v=0 m=000000 n=0", out_valid, out_mant, out_norm);
        end
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid !== 1'b0) seen = 1'b1;
        end
        checks++; if (seen) begin errors++; $display("FAIL rstmid_no_output: got out_valid high expected none"); end
        test_product("rstmid_fresh", 0, 23'h400000, 23'h400000, 23'h100000, 1'b1);
    endtask

    initial begin
        test_reset();
        test_product("unity", 0, 23'h000000, 23'h000000, 23'h000000, 1'b0);
        test_product("one_half_sq", 0, 23'h400000, 23'h400000, 23'h100000, 1'b1);
        test_product("max_trunc", 1, 23'h7FFFFF, 23'h7FFFFF, 23'h7FFFFE, 1'b1);
        test_arbitration();
        test_backpressure();
        test_reset_mid_calc();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_mantissa_mul_sequencer
